// File: rtl/serial_shifter_pkg.sv
// Shared encodings and default sizes for the multicycle shift/rotate engine.
package serial_shifter_pkg;

   localparam int unsigned WIDTH_DEF = 16;
   localparam int unsigned CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      OP_ROL = 2'b00,
      OP_SLL = 2'b01,
      OP_ROR = 2'b10,
      OP_SRL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/serial_shifter_step.sv
// Combinational single-bit shift/rotate move; one instance drives the top-level result register.
module shift1_step
   import serial_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] x,
   input  op_e              op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = x;
      unique case (op)
         OP_ROL:  y = {x[WIDTH-2:0], x[WIDTH-1]};
         OP_SLL:  y = {x[WIDTH-2:0], 1'b0};
         OP_ROR:  y = {x[0], x[WIDTH-1:1]};
         OP_SRL:  y = {1'b0, x[WIDTH-1:1]};
         default: y = x;
      endcase
   end

endmodule

// File: rtl/serial_shifter.sv
// Multicycle shift/rotate engine: one bit position per clock, start/done handshake.
module serial_shifter
   import serial_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       op,
   input  logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] step_y;

   shift1_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .x  (out_q),
      .op (op_q),
      .y  (step_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_ROL;
         rem_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      out_d   = out_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            done    = (state_q == DONE);
            state_d = IDLE;
            if (start) begin
               out_d   = in;
               op_d    = op_e'(op);
               rem_d   = cnt;
               state_d = (cnt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            busy  = 1'b1;
            out_d = step_y;
            rem_d = rem_q - CNT_W'(1);
            // rem never reaches zero here, so the down-counter cannot wrap
            if (rem_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out = out_q;

endmodule

// File: doc/serial_shifter.md
Name: serial_shifter

Overview:
- Multi-cycle 16-bit shift/rotate engine: one bit position per clock, under a start/done handshake.
- Covers all four ISA shift ops, including the right-hand directions: ROL, SLL, ROR, SRL.
- Serves the multicycle execute path, where the single-cycle shift datapath is too slow or too large.
- The ALU launches an operation with start, then captures out on the done pulse.

Parameters:
- WIDTH, 16, data width in bits.
- CNT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch request; sampled only when the engine is not busy.
- in  in  WIDTH  operand; captured on accepted start.
- op  in  2  shift op, captured on accepted start: 00 ROL, 01 SLL, 10 ROR, 11 SRL.
- cnt  in  CNT_W  shift amount, 0..15; captured on accepted start.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse; out is valid from this cycle on.
- out  out  WIDTH  result register.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, out=0, busy=0, done=0, internal shadow registers=0. Applies immediately on rst assertion, including mid-operation; the operation in flight is abandoned with no done.
- States and outputs:
  - IDLE and DONE both accept start.
  - busy=1 only in SHIFT.
  - done=1 only in DONE.
- Accepted start (state IDLE or DONE, start=1):
  - Captures in→out, op→op_q, cnt→rem.
  - Next state is SHIFT if cnt!=0, else DONE.
- SHIFT, each cycle:
  - out ← step(out, op_q), rem ← rem−1.
  - When rem==1 (the final step), next state is DONE; otherwise stay in SHIFT.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is IDLE, unless start=1, which performs an accepted start (back-to-back ops allowed).
- IDLE with start=0: hold; out retains the last result.
- start while in SHIFT: ignored, with no queueing. Inputs in/op/cnt are don't-care except on an accepted start.
- Latency: done asserts cnt+1 cycles after the start edge, i.e. 1 cycle for cnt=0 (out=in unchanged) and 16 cycles for cnt=15.
- step() definition, 1-bit move per op:
  - ROL: {x[14:0], x[15]}
  - SLL: {x[14:0], 1'b0}
  - ROR: {x[0], x[15:1]}
  - SRL: {1'b0, x[15:1]}
- Arithmetic: rem is a CNT_W-bit down-counter and never wraps, because SHIFT always exits at rem==1. No arithmetic-right op is supported.
- done and busy are never high together. out changes only on an accepted start, in SHIFT, or on reset.

Decomposition:
- Shared package holds:
  - op encodings: OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11
  - state encoding: IDLE, SHIFT, DONE (2 bits)
  - WIDTH and CNT_W defaults
- One combinational sub-module, shift1_step(x, op) → y, implements the single-bit move above. The top level holds the FSM, rem counter and out register, and instantiates shift1_step once.

Test Plan:
- ROL, in=0x8001, cnt=1 → done 2 cycles after start, out=0x0003, busy high for 1 cycle.
- SLL, in=0x00FF, cnt=4 → out=0x0FF0 on the done pulse, 5 cycles after start; done width exactly 1 cycle.
- ROR, in=0x0001, cnt=15 → out=0x0002 after 16 cycles; SRL, in=0x8000, cnt=15 → out=0x0001.
- cnt=0, in=0xBEEF, any op → done the next cycle, out=0xBEEF, busy never asserted.
- Start SLL 0x1234 cnt=8; pulse start with in=0xFFFF during SHIFT → ignored, result 0x3400. Start asserted in the DONE cycle → new op accepted with no IDLE gap.
- Assert rst asynchronously mid-shift (between clock edges) → out=0, busy=0, done=0 immediately, no done pulse after release; the next start works normally.
